// File: rtl/draw_poly_if.sv
// Command/pixel bundle between the shape command logic, draw_poly and the framebuffer port.
// The master drives the polygon request; the slave (rasteriser) returns pixels and status.
interface draw_poly_if #(
    parameter int CORDW = 16,
    parameter int NV    = 8
);
    localparam int NW = $clog2(NV + 1);

    logic                    start;
    logic                    abort;
    logic                    oe;
    logic                    closed;
    logic [NW-1:0]           nv;
    logic [NV*CORDW-1:0]     vx;
    logic [NV*CORDW-1:0]     vy;
    logic signed [CORDW-1:0] x;
    logic signed [CORDW-1:0] y;
    logic                    drawing;
    logic                    busy;
    logic                    done;

    modport master (
        output start, abort, oe, closed, nv, vx, vy,
        input  x, y, drawing, busy, done
    );

    modport slave (
        input  start, abort, oe, closed, nv, vx, vy,
        output x, y, drawing, busy, done
    );
endinterface

// File: rtl/draw_poly.sv
// Polygon/polyline rasteriser: walks up to NV vertices edge by edge with a Bresenham engine,
// emitting one pixel per enabled cycle and hiding the pixels shared between adjacent edges.
module draw_poly #(
    parameter int CORDW = 16,
    parameter int NV    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    draw_poly_if.slave  bus
);
    localparam int NW = $clog2(NV + 1);
    localparam int AW = (NV > 1) ? $clog2(NV) : 1;
    localparam int EW = CORDW + 2;

    typedef enum logic [1:0] {IDLE, INIT, DRAW} state_t;
    state_t state;

    logic signed [CORDW-1:0] vxa [NV];
    logic signed [CORDW-1:0] vya [NV];
    logic [NW-1:0]           n_r, e, last_e;
    logic                    close_edge, first;
    logic signed [CORDW-1:0] x, y, x1, y1;
    logic signed [CORDW:0]   dx, dy;
    logic signed [EW-1:0]    err;
    logic                    sx_neg, sy_neg, busy_r, done_r;

    // Request decode at start time: clamp vertex count and find the index of the final edge.
    logic [NW-1:0] n_in, last_in;
    always_comb begin
        n_in = (bus.nv > NW'(NV)) ? NW'(NV) : bus.nv;
        if (bus.closed && n_in >= NW'(3))
            last_in = n_in - NW'(1);
        else if (n_in >= NW'(2))
            last_in = n_in - NW'(2);
        else
            last_in = '0;
    end

    logic [NW-1:0]           e_end;
    logic signed [CORDW-1:0] ax0, ay0, ax1, ay1;
    logic signed [CORDW:0]   x0e, y0e, x1e, y1e, dx_i, dy_i;
    logic signed [EW-1:0]    err_i;
    always_comb begin
        e_end = (e + NW'(1) == n_r) ? '0 : e + NW'(1);
        ax0   = vxa[e[AW-1:0]];
        ay0   = vya[e[AW-1:0]];
        ax1   = vxa[e_end[AW-1:0]];
        ay1   = vya[e_end[AW-1:0]];
        x0e   = (CORDW+1)'(ax0);
        y0e   = (CORDW+1)'(ay0);
        x1e   = (CORDW+1)'(ax1);
        y1e   = (CORDW+1)'(ay1);
        dx_i  = (x1e >= x0e) ? x1e - x0e : x0e - x1e;
        dy_i  = (y1e >= y0e) ? y0e - y1e : y1e - y0e;
        err_i = EW'(dx_i) + EW'(dy_i);
    end

    logic signed [EW:0]   e2, dx_w, dy_w;
    logic signed [EW-1:0] err_n;
    logic                 step_x, step_y, at_end, suppressed;
    always_comb begin
        e2     = {err, 1'b0};
        dx_w   = (EW+1)'(dx);
        dy_w   = (EW+1)'(dy);
        step_x = (e2 >= dy_w);
        step_y = (e2 <= dx_w);
        err_n  = err + (step_x ? EW'(dy) : EW'(0)) + (step_y ? EW'(dx) : EW'(0));
        at_end = (x == x1) && (y == y1);
        // Shared vertices: later edges skip their start, the closing edge also skips its end.
        suppressed = (first && e != '0) || (close_edge && at_end);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            for (int i = 0; i < NV; i++) begin
                vxa[i] <= '0;
                vya[i] <= '0;
            end
            n_r        <= '0;
            e          <= '0;
            last_e     <= '0;
            close_edge <= 1'b0;
            first      <= 1'b0;
            x          <= '0;
            y          <= '0;
            x1         <= '0;
            y1         <= '0;
            dx         <= '0;
            dy         <= '0;
            err        <= '0;
            sx_neg     <= 1'b0;
            sy_neg     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < NV; i++) begin
                            vxa[i] <= bus.vx[i*CORDW +: CORDW];
                            vya[i] <= bus.vy[i*CORDW +: CORDW];
                        end
                        n_r    <= n_in;
                        last_e <= last_in;
                        e      <= '0;
                        if (n_in == '0) begin
                            done_r <= 1'b1;
                        end else begin
                            busy_r <= 1'b1;
                            state  <= INIT;
                        end
                    end
                end
                INIT: begin
                    if (bus.abort) begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end else if (bus.oe) begin
                        x          <= ax0;
                        y          <= ay0;
                        x1         <= ax1;
                        y1         <= ay1;
                        dx         <= dx_i;
                        dy         <= dy_i;
                        err        <= err_i;
                        sx_neg     <= (x1e < x0e);
                        sy_neg     <= (y1e < y0e);
                        close_edge <= (n_r >= NW'(3)) && (e_end == '0);
                        first      <= 1'b1;
                        state      <= DRAW;
                    end
                end
                DRAW: begin
                    if (bus.abort) begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end else if (bus.oe) begin
                        first <= 1'b0;
                        if (at_end) begin
                            if (e == last_e) begin
                                busy_r <= 1'b0;
                                done_r <= 1'b1;
                                state  <= IDLE;
                            end else begin
                                e     <= e + NW'(1);
                                state <= INIT;
                            end
                        end else begin
                            err <= err_n;
                            if (step_x) x <= sx_neg ? x - CORDW'(1) : x + CORDW'(1);
                            if (step_y) y <= sy_neg ? y - CORDW'(1) : y + CORDW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.x       = x;
    assign bus.y       = y;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.drawing = (state == DRAW) && bus.oe && !suppressed;
endmodule

// File: doc/draw_poly.md
# draw_poly

Parametrised polygon/polyline rasteriser and successor to the four-vertex quad drawer. It accepts up to NV vertices and draws either an open polyline or a closed polygon with an internal Bresenham line engine. It emits one pixel per enabled cycle, suppresses pixels at shared vertices, and supports abort. It sits between the shape command logic and the framebuffer write port.

## Interface
- CORDW, 16: signed coordinate width.
- NV, 8: maximum vertex count (≥3).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request drawing; sampled only in IDLE.
- abort  in  1  cancel in-progress drawing.
- oe  in  1  output enable; low stalls the engine.
- closed  in  1  1 = add closing edge v[n-1]→v[0]; sampled with start.
- nv  in  $clog2(NV+1)  active vertex count; sampled with start.
- vx, vy  in  NV*CORDW each  vertex i at [i*CORDW +: CORDW], signed.
- x, y  out  CORDW each  signed current pixel position.
- drawing  out  1  x,y is a valid pixel this cycle.
- busy  out  1  request in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, INIT, DRAW.
- IDLE, start=1: snapshot vx, vy, closed, nv into internal registers; later input changes have no effect.
  - n = min(nv, NV); edge index e = 0; busy←1; go to INIT.
- nv=0: go from IDLE straight to done, with no pixels.
- Edge list:
  - e = 0..n-2: v[e]→v[e+1].
  - If closed and n≥3, add v[n-1]→v[0].
  - n=1 gives one edge v[0]→v[0].
  - closed is ignored for n≤2.
- INIT: load endpoints, then x,y←start point.
  - dx = |x1-x0|, dy = -|y1-y0|, computed at CORDW+1 bits.
  - err = dx+dy at CORDW+2 bits; step signs are set from the endpoint comparison.
  - Then go to DRAW.
- DRAW, oe=1: the current position is consumed.
  - If it is not the end point, take a standard Bresenham step with e2 = 2·err.
    - If e2≥dy, then x±1 and err+=dy.
    - If e2≤dx, then y±1 and err+=dx.
  - If it is the end point: go to INIT for the next edge, or go to IDLE with busy←0 and done←1.
- DRAW, oe=0: hold x, y, err and state.
- Vertex de-duplication:
  - Edges e>0 suppress their start pixel.
  - The closing edge also suppresses its end pixel.
  - A suppressed position still takes one DRAW cycle, with drawing low.
- drawing = (state==DRAW) & oe & ~suppressed; this is combinational from registered state.
- abort=1 in INIT or DRAW: next state IDLE, busy←0, no done pulse. abort in IDLE has no effect.
- Simultaneous abort and start in IDLE: start wins.
- start while busy: ignored.
- Coordinates are signed and may be negative; there is no clipping.
- Reset, async on rst_n low: state IDLE, e=0, x=y=0, drawing=0, busy=0, done=0. Reset mid-draw discards the request.

## Timing
- Start sampled at edge T: INIT runs in cycle T..T+1, and the first pixel appears in cycle T+1..T+2.
- Each edge costs 1 INIT cycle plus (max(dx,|dy|)+1) DRAW cycles at oe=1; each oe=0 cycle adds one cycle.
- busy rises in the cycle after the start edge. It falls in the same cycle done rises.
- done is registered and high exactly one cycle. It is cleared in the next IDLE cycle.
- nv=0: done is high in the cycle after the start edge.
- A new start is accepted in the cycle done is high, since the state is already IDLE.

## Test plan
- Closed square, CORDW=16, NV=8, nv=4: vertices (0,0),(3,0),(3,3),(0,3), oe=1.
  - 12 distinct perimeter pixels, no duplicates.
  - done is high after the 20th edge following start.
- Open polyline, nv=3: (0,0)→(4,2)→(4,-1).
  - 5 Bresenham pixels, then 3 pixels (4,1),(4,0),(4,-1). The start (4,2) is suppressed.
  - (0,0) appears exactly once.
- Stall: same square with oe toggling 1,0,1,0…
  - Identical pixel sequence.
  - x,y are held on oe=0 cycles.
  - done is delayed by exactly the number of oe=0 cycles in INIT/DRAW.
- Boundaries:
  - nv=0 → done with no drawing.
  - nv=1 at (-5,7) → single pixel (-5,7).
  - nv=12 with NV=8 → treated as 8.
  - closed with nv=2 → no closing edge.
- Abort and reset mid-draw:
  - abort during edge 1 → IDLE next cycle, busy=0, no done; a subsequent start draws a full polygon.
  - rst_n low mid-draw → all outputs 0 immediately.
- Snapshot and start rules:
  - Change vx/vy/nv and pulse start while busy → the in-flight polygon is unchanged and the second start is ignored.
